// File: rtl/alu_decode_stage.sv
// RV32I decode stage: instruction+PC in, ALU op/operand selects/immediate/strobes out via a 2-entry skid buffer.
// Latency 1 cycle from accept to out_valid; 1 instr/cycle when out_ready is high.
// in_ready is registered and falls only when both entries hold data. `ALU_DEC_ILLEGAL_EN` raises `illegal` on bad encodings.
module alu_decode_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [OPW-1:0]   alu_op,
    output logic [1:0]       a_sel,
    output logic             b_sel,
    output logic [WIDTH-1:0] imm,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             branch,
    output logic             jump,
    output logic             br_on_zero,
    output logic             illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
    localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
    localparam logic [OPW-1:0] ALU_SLL  = OPW'(2);
    localparam logic [OPW-1:0] ALU_SLT  = OPW'(3);
    localparam logic [OPW-1:0] ALU_SLTU = OPW'(4);
    localparam logic [OPW-1:0] ALU_XOR  = OPW'(5);
    localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
    localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
    localparam logic [OPW-1:0] ALU_OR   = OPW'(8);
    localparam logic [OPW-1:0] ALU_AND  = OPW'(9);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [OPW-1:0]   alu_op;
        logic [1:0]       a_sel;
        logic             b_sel;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic             branch;
        logic             jump;
        logic             br_on_zero;
        logic             illegal;
    } dec_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    function automatic logic [OPW-1:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [OPW-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [WIDTH-1:0] sext(input logic [31:0] v);
        return WIDTH'($signed(v));
    endfunction

    logic [31:0] ins;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        bad;
    dec_t        dec;

    assign ins    = in_instr[31:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        bad     = 1'b0;
        dec     = '0;
        dec.pc  = in_pc;
        dec.rd  = ins[11:7];
        dec.rs1 = ins[19:15];
        dec.rs2 = ins[24:20];
        dec.imm = sext(imm_i);
        case (ins[6:0])
            OPC_OP: begin
                dec.reg_we = 1'b1;
                dec.alu_op = arith_op(funct3, funct7[5]);
                case (funct7)
                    7'b0000000: bad = 1'b0;
                    7'b0100000: bad = !(funct3 == 3'b000 || funct3 == 3'b101);
                    default:    bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.reg_we = 1'b1;
                dec.b_sel  = 1'b1;
                dec.alu_op = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
                // Shift-immediates carry shamt, not a sign-extended constant.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.imm = WIDTH'(ins[24:20]);
                    bad     = !(funct7 == 7'b0000000 || (funct3 == 3'b101 && funct7 == 7'b0100000));
                end
            end
            OPC_LOAD: begin
                dec.b_sel  = 1'b1;
                dec.mem_re = 1'b1;
                dec.reg_we = 1'b1;
                bad        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.b_sel  = 1'b1;
                dec.mem_we = 1'b1;
                dec.imm    = sext(imm_s);
                bad        = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = sext(imm_b);
                case (funct3)
                    3'b000: begin dec.alu_op = ALU_SUB;  dec.br_on_zero = 1'b1; end
                    3'b001: dec.alu_op = ALU_SUB;
                    3'b100: dec.alu_op = ALU_SLT;
                    3'b101: begin dec.alu_op = ALU_SLT;  dec.br_on_zero = 1'b1; end
                    3'b110: dec.alu_op = ALU_SLTU;
                    3'b111: begin dec.alu_op = ALU_SLTU; dec.br_on_zero = 1'b1; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.a_sel  = (ins[6:0] == OPC_LUI) ? 2'b10 : 2'b01;
                dec.b_sel  = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = sext(imm_u);
            end
            OPC_JAL: begin
                dec.a_sel  = 2'b01;
                dec.b_sel  = 1'b1;
                dec.jump   = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = sext(imm_j);
            end
            OPC_JALR: begin
                dec.b_sel  = 1'b1;
                dec.jump   = 1'b1;
                dec.reg_we = 1'b1;
                bad        = (funct3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase
        // Bad encodings collapse to a side-effect-free add so execute never acts on them.
        if (bad) begin
            dec.alu_op     = ALU_ADD;
            dec.a_sel      = 2'b00;
            dec.b_sel      = 1'b0;
            dec.imm        = sext(imm_i);
            dec.reg_we     = 1'b0;
            dec.mem_re     = 1'b0;
            dec.mem_we     = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
            dec.br_on_zero = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
            dec.illegal    = 1'b1;
`else
            dec.illegal    = 1'b0;
`endif
        end
    end

    state_t state_q, state_d;
    dec_t   head_q, head_d, tail_q, tail_d;
    logic   out_vld_q, out_vld_d, in_rdy_q, in_rdy_d;
    logic   acc, drn;

    // Handshakes are masked while rst is high so nothing transfers during reset.
    assign in_ready  = in_rdy_q & ~rst;
    assign out_valid = out_vld_q & ~rst;
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: if (acc) begin state_d = S_ONE; head_d = dec; end
            S_ONE: begin
                if (acc && drn) begin
                    head_d = dec;
                end else if (acc) begin
                    state_d = S_TWO;
                    tail_d  = dec;
                end else if (drn) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: if (drn) begin state_d = S_ONE; head_d = tail_q; end
            default: state_d = S_EMPTY;
        endcase
        out_vld_d = (state_d != S_EMPTY);
        in_rdy_d  = (state_d != S_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            out_vld_q <= out_vld_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

    assign out_pc     = head_q.pc;
    assign alu_op     = head_q.alu_op;
    assign a_sel      = head_q.a_sel;
    assign b_sel      = head_q.b_sel;
    assign imm        = head_q.imm;
    assign rd         = head_q.rd;
    assign rs1        = head_q.rs1;
    assign rs2        = head_q.rs2;
    assign reg_we     = head_q.reg_we;
    assign mem_re     = head_q.mem_re;
    assign mem_we     = head_q.mem_we;
    assign branch     = head_q.branch;
    assign jump       = head_q.jump;
    assign br_on_zero = head_q.br_on_zero;
    assign illegal    = head_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: random and directed instructions, expected bundles queued at accept time
// and popped by an independent output monitor; also checks reset, backpressure and reset-while-full.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_we, mem_re, mem_we, branch, jump, br_on_zero, illegal;

    always #5 clk = ~clk;

    alu_decode_stage #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel), .imm(imm),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .branch(branch), .jump(jump),
        .br_on_zero(br_on_zero), .illegal(illegal)
    );

`ifdef ALU_DEC_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        reg_we, mem_re, mem_we, branch, jump, br_on_zero, illegal;
    } bun_t;

    bun_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference decode written from the ISA field definitions.
    function automatic bun_t model(input logic [31:0] ins, input logic [31:0] pc);
        bun_t       b;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         legal, alt, sh;
        int         base [8];
        int         i_imm, s_imm, b_imm, j_imm;
        base  = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3    = ins[14:12];
        f7    = ins[31:25];
        alt   = (f7 == 7'h20);
        sh    = (f3 == 3'd1 || f3 == 3'd5);
        i_imm = $signed(ins) >>> 20;
        s_imm = (i_imm >>> 5) * 32 + int'(ins[11:7]);
        b_imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        j_imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        b     = '0;
        b.pc  = pc;
        b.rd  = ins[11:7];
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        b.imm = 32'(i_imm);
        legal = 1'b1;
        case (ins[6:0])
            7'h33: begin
                legal    = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
                b.alu_op = 4'(base[f3] + (alt ? 1 : 0));
                b.reg_we = 1'b1;
            end
            7'h13: begin
                legal    = !sh || (f7 == 7'h00) || (f3 == 3'd5 && alt);
                b.alu_op = 4'(base[f3] + ((f3 == 3'd5 && alt) ? 1 : 0));
                b.b_sel  = 1'b1;
                b.reg_we = 1'b1;
                if (sh) b.imm = 32'(ins[24:20]);
            end
            7'h03: begin
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                b.b_sel = 1'b1; b.mem_re = 1'b1; b.reg_we = 1'b1;
            end
            7'h23: begin
                legal = (f3 <= 3'd2);
                b.imm = 32'(s_imm); b.b_sel = 1'b1; b.mem_we = 1'b1;
            end
            7'h63: begin
                legal        = !(f3 == 3'd2 || f3 == 3'd3);
                b.alu_op     = (f3 < 3'd4) ? 4'd1 : ((f3 < 3'd6) ? 4'd3 : 4'd4);
                b.br_on_zero = (f3 < 3'd4) ? !f3[0] : f3[0];
                b.imm        = 32'(b_imm);
                b.branch     = 1'b1;
            end
            7'h37: begin b.a_sel = 2'd2; b.imm = ins & 32'hFFFFF000; b.b_sel = 1'b1; b.reg_we = 1'b1; end
            7'h17: begin b.a_sel = 2'd1; b.imm = ins & 32'hFFFFF000; b.b_sel = 1'b1; b.reg_we = 1'b1; end
            7'h6F: begin b.a_sel = 2'd1; b.imm = 32'(j_imm); b.b_sel = 1'b1; b.jump = 1'b1; b.reg_we = 1'b1; end
            7'h67: begin legal = (f3 == 3'd0); b.b_sel = 1'b1; b.jump = 1'b1; b.reg_we = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            b.alu_op = '0; b.a_sel = '0; b.b_sel = 1'b0; b.imm = 32'(i_imm);
            b.reg_we = 1'b0; b.mem_re = 1'b0; b.mem_we = 1'b0; b.branch = 1'b0;
            b.jump = 1'b0; b.br_on_zero = 1'b0; b.illegal = ILL_EN;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        w   = $urandom;
        k   = $urandom_range(0, 9);
        if (k < 9) w[6:0] = ops[k];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            k = $urandom_range(0, 3);
            if (k < 2) w[31:25] = 7'h00;
            else if (k == 2) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit use_exp, input bun_t e);
        int waitc;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        #1;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (in_ready) begin
            exp_q.push_back(use_exp ? e : model(ins, pc));
            acc_cnt++;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at %b for instr %h", in_ready, ins);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = $urandom;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per output handshake, and checks that a stalled head does not move.
    initial begin
        bun_t act, held;
        bit   holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst || !out_valid) begin
                holding = 1'b0;
            end else begin
                act.pc = out_pc; act.alu_op = alu_op; act.a_sel = a_sel; act.b_sel = b_sel;
                act.imm = imm; act.rd = rd; act.rs1 = rs1; act.rs2 = rs2;
                act.reg_we = reg_we; act.mem_re = mem_re; act.mem_we = mem_we; act.branch = branch;
                act.jump = jump; act.br_on_zero = br_on_zero; act.illegal = illegal;
                if (holding) check("stall_stable", act, held);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", act);
                    end else begin
                        check("bundle", act, exp_q.pop_front());
                    end
                    holding = 1'b0;
                end else begin
                    held    = act;
                    holding = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        bun_t        e;
        logic [31:0] pc;
        int          base;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc    = '0;
        pc       = 32'h1000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_imm", imm, 0);
        check("rst_a_sel", a_sel, 0);
        check("rst_strobes", {reg_we, mem_re, mem_we, branch, jump, br_on_zero, illegal}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Directed vectors with hand-derived expectations.
        e = '0; e.pc = 32'h100; e.rd = 5'd1; e.rs1 = 5'd2; e.rs2 = 5'd3; e.imm = 32'h3; e.reg_we = 1'b1;
        send(32'h003100B3, 32'h100, 1'b1, e);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("latency_1cyc", out_valid, 1);
        e = '0; e.pc = 32'h104; e.alu_op = 4'd7; e.rd = 5'd5; e.rs1 = 5'd6; e.rs2 = 5'd3;
        e.imm = 32'h3; e.b_sel = 1'b1; e.reg_we = 1'b1;
        send(32'h40335293, 32'h104, 1'b1, e);
        e = '0; e.pc = 32'h108; e.alu_op = 4'd1; e.rd = 5'd8; e.rs1 = 5'd1; e.rs2 = 5'd2;
        e.imm = 32'h8; e.branch = 1'b1; e.br_on_zero = 1'b0;
        send(32'h00209463, 32'h108, 1'b1, e);
        e = '0; e.pc = 32'h10C; e.alu_op = 4'd0; e.a_sel = 2'b10; e.imm = 32'h12345000; e.b_sel = 1'b1;
        e.reg_we = 1'b1; e.rd = 5'd7; e.rs1 = 5'd8; e.rs2 = 5'd3;
        send(32'h123453B7, 32'h10C, 1'b1, e);
        e = '0; e.pc = 32'h110; e.rd = 5'd31; e.rs1 = 5'd31; e.rs2 = 5'd31; e.imm = 32'hFFFFFFFF;
        e.illegal = ILL_EN;
        send(32'hFFFFFFFF, 32'h110, 1'b1, e);
        idle();

        // Random traffic, first with a free-running sink, then with random backpressure.
        for (int ph = 0; ph < 2; ph++) begin
            rdy_mode = ph;
            for (int n = 0; n < 150; n++) begin
                send(rand_instr(), pc, 1'b0, '0);
                pc += 4;
                if ($urandom_range(0, 4) == 0) idle();
            end
            idle();
        end
        rdy_mode = 0;
        wait_drain();

        // Backpressure: 4 back-to-back instructions into a stalled sink.
        rdy_mode = 2;
        idle();
        idle();
        base = acc_cnt;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send(rand_instr(), pc, 1'b0, '0);
                    pc += 4;
                end
                idle();
            end
            begin
                @(negedge clk);
                @(negedge clk);
                #3;
                check("bp_ready_after_1", in_ready, 1);
                @(negedge clk);
                #3;
                check("bp_ready_drop", in_ready, 0);
                check("bp_accepts", acc_cnt - base, 2);
                check("bp_out_valid", out_valid, 1);
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Reset while both entries are full discards them.
        rdy_mode = 2;
        idle();
        idle();
        send(rand_instr(), pc, 1'b0, '0);
        send(rand_instr(), pc + 4, 1'b0, '0);
        pc += 8;
        idle();
        #1;
        check("two_in_ready", in_ready, 0);
        check("two_out_valid", out_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_alu_op", alu_op, 0);
        check("flush_imm", imm, 0);
        rst = 1'b0;
        #1;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid_after", out_valid, 0);

        rdy_mode = 1;
        for (int n = 0; n < 100; n++) begin
            send(rand_instr(), pc, 1'b0, '0);
            pc += 4;
        end
        idle();
        rdy_mode = 0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Pipelined RV32I instruction-decode stage that feeds the ALU. It accepts a fetched instruction and its PC over a valid/ready handshake, and decodes them into the ALU's 4-bit operation code, operand selects, immediate, register indices and control strobes. Results are registered through a 2-entry skid buffer, so the stage sustains one instruction per cycle under downstream backpressure. It sits between fetch and the execute stage (register-file read plus ALU).

## Interface
- `WIDTH`, 32, instruction/PC/immediate width
- `OPW`, 4, ALU opcode width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction valid
- `in_ready`  out  1  stage can accept
- `in_instr`  in  WIDTH  instruction word
- `in_pc`  in  WIDTH  instruction PC
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  execute stage accepts
- `out_pc`  out  WIDTH  PC passed through
- `alu_op`  out  OPW  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and
- `a_sel`  out  2  ALU A source: 00 rs1, 01 pc, 10 zero
- `b_sel`  out  1  ALU B source: 0 rs2, 1 imm
- `imm`  out  WIDTH  sign-extended immediate
- `rd`, `rs1`, `rs2`  out  5 each  register indices
- `reg_we`, `mem_re`, `mem_we`, `branch`, `jump`  out  1 each  control strobes
- `br_on_zero`  out  1  branch taken when ALU zero_flag equals this bit
- `illegal`  out  1  instruction not decodable

## Operation
- Handshake: a transfer occurs when valid && ready on that side. `in_valid` held with `in_instr` stable until accepted.
- Skid buffer states: EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE: accept without drain → TWO; drain without accept → EMPTY; both → ONE.
  - TWO: drain → ONE; no accept in TWO.
- `in_ready` = registered (state != TWO).
- Bundles leave in order; `out_*` reflect the head entry and stay stable while `out_valid && !out_ready`.
- Decode by opcode[6:0]:
  - OP: funct3 selects op. 000 → add, or sub when funct7[5]. 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7[5], 110 or, 111 and. `b_sel`=0, `reg_we`=1.
  - OP-IMM: same mapping, with funct3 000 always add. I-imm, `b_sel`=1. For shifts, imm = zero-extended shamt[4:0].
  - LOAD/STORE: add, I/S-imm; `mem_re`/`mem_we`; LOAD sets `reg_we`.
  - BRANCH: BEQ/BNE → sub; BLT/BGE → slt; BLTU/BGEU → sltu. `br_on_zero`=1 for BEQ/BGE/BGEU, 0 for BNE/BLT/BLTU. B-imm, `b_sel`=0.
  - LUI: add, `a_sel`=zero, U-imm. AUIPC: add, `a_sel`=pc, U-imm.
  - JAL: add, `a_sel`=pc, J-imm, `jump`=1, `reg_we`=1. JALR: add, `a_sel`=rs1, I-imm, `jump`=1, `reg_we`=1.
- Illegal encodings:
  - unknown opcode;
  - OP funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101};
  - OP-IMM shift with a bad funct7;
  - BRANCH funct3 010/011;
  - LOAD funct3 011/110/111;
  - STORE funct3 > 010;
  - JALR funct3 != 000.
- Fields not used by a format are still driven from the raw instruction bits.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput: 1 per cycle with `out_ready`=1.
- Reset: buffer set to EMPTY. All outputs are 0 during reset (`in_ready`, `out_valid`, `alu_op`, `imm`, `a_sel`, strobes), and `in_ready` is 1 on the first cycle after `rst` deasserts.
- Reset mid-operation discards both entries with no output handshake.
- Simultaneous accept and drain in ONE: the new entry becomes head next cycle with no bubble.
- `out_ready` deasserted in ONE: entry held, next input captured, `in_ready` falls the following cycle.

## Configuration
- `ALU_DEC_ILLEGAL_EN` defined:
  - illegal encodings set `illegal`=1;
  - `reg_we`, `mem_re`, `mem_we`, `branch` and `jump` are forced to 0;
  - `alu_op`=0.
- Undefined:
  - `illegal` is tied 0;
  - illegal encodings decode as a NOP (add, `reg_we`=0, all strobes 0).

## Test plan
- `0x003100B3` (add x1,x2,x3), `out_ready`=1 → next cycle `out_valid`=1, `alu_op`=0, rd=1, rs1=2, rs2=3, `b_sel`=0, `reg_we`=1.
- `0x40335293` (srai x5,x6,3) → `alu_op`=7, imm=3, `b_sel`=1, rd=5.
- `0x00209463` (bne x1,x2,+8) → `alu_op`=1, imm=8, `branch`=1, `br_on_zero`=0, `reg_we`=0.
- `0x123453B7` (lui x7,0x12345) → `alu_op`=0, `a_sel`=10, imm=0x12345000.
- Backpressure:
  - stimulus: stream 4 instructions with `out_ready`=0 for 3 cycles;
  - response: `in_ready` drops after 2 accepts, `out_*` is stable, and all 4 emerge in order once `out_ready`=1;
  - also pulse `rst` while the buffer is in TWO → `out_valid`=0 next cycle.
- `0xFFFFFFFF`:
  - with `ALU_DEC_ILLEGAL_EN`: `illegal`=1, all strobes 0;
  - without it: `illegal`=0, NOP decode.
